fsm_pattern_tx: RTL
===================

# fsm_pattern_tx

Bit-serial pattern transmitter: accepts a parallel word through a ready/load handshake and shifts it out MSB-first on a single serial line, one bit per clock. It drives the `A` input of the team's serial sequence-detector FSMs, such as the 01001 lock detector, so detectors can be exercised from RTL rather than bench-side shifting. It is a Moore machine: all outputs are registered or decoded from state only.

## Interface
- `WIDTH`, 16: maximum frame length in bits; the data word width.
- `LEN_W`, `$clog2(WIDTH+1)`: width of the `len` port (derived; do not override).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `load`  in  1  request to start a frame; sampled only while `ready`=1.
- `data`  in  WIDTH  frame bits; `data[WIDTH-1]` is sent first.
- `len`  in  LEN_W  number of bits to send; 0 means WIDTH; values above WIDTH saturate to WIDTH.
- `ready`  out  1  transmitter can accept `load`.
- `A`  out  1  serial output bit; idle level 0.
- `a_valid`  out  1  `A` carries a frame bit this cycle.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `ready`=1, `A`=0, `a_valid`=0. If `load` is high at a clock edge, latch `data` into the shift register and the effective length into the bit counter, then go to SHIFT.
- SHIFT: `A` = shift register MSB, `a_valid`=1, `ready`=0. Each edge shifts left by 1 (zero fill) and decrements the counter. When the counter reaches 1 at an edge, go to DONE.
- DONE: `done`=1, `ready`=1, `A`=0, `a_valid`=0. If `load` is high, latch the new frame and go to SHIFT. Otherwise go to IDLE.
- `load` while `ready`=0 is ignored and never queued. `data`/`len` changes during SHIFT have no effect.
- Counter is LEN_W bits, loaded with `len==0 || len>WIDTH ? WIDTH : len`. It never wraps.
- Reset, including mid-frame: state IDLE, shift register 0, counter 0, `ready`=1, `A`=0, `a_valid`=0, `done`=0. The partial frame is discarded.

## Timing
- If `load` is accepted at edge k, bit i (i = 0..n-1, MSB first) is on `A` during the cycle after edge k+i. `a_valid` is high for exactly n consecutive cycles.
- `done` is high for the single cycle after the last bit.
- Back-to-back operation: `load` accepted in the DONE cycle gives exactly one idle cycle (`A`=0) between frames. Throughput is n bits per n+1 cycles.
- `ready` is high in IDLE and DONE only. It never depends combinationally on `load`.
- `len`=1 gives one bit cycle, then DONE.

## Configuration
- `PATTERN_TX_LOOP_EN` defined: adds input `loop` (1 bit).
  - When SHIFT sends its last bit while `loop`=1, the FSM reloads the latched frame and stays in SHIFT. The first bit of the repeat follows the last bit with no gap.
  - `done` is not pulsed between repeats.
  - Deasserting `loop` ends the sequence after the current frame completes, followed by the normal DONE cycle.
- Macro undefined: no `loop` port; every frame is sent exactly once.

## Structure
- Package `fsm_pattern_pkg` holds the `state_t` enum (IDLE, SHIFT, DONE) and the default `WIDTH` constant.
- Sub-module `pattern_bit_cnt`: loadable down-counter with `load`, `dec`, `value`, and `last` (value==1) outputs. The shift register and FSM stay in the top module.

## Test plan
- Reset held, then released: `ready`=1, `A`=0, `a_valid`=0, `done`=0. Assert `reset` low mid-frame: the same values appear immediately, and no `done` pulse follows.
- `data`=16'b1010010011010011, `len`=0, single `load` → `A` reads 1,0,1,0,0,1,0,0,1,1,0,1,0,0,1,1 over 16 valid cycles, then `done` for 1 cycle. A downstream 01001 detector unlocks twice.
- `len`=5, `data`=16'b0100_1xxx_xxxx_xxxx → 5 bits 0,1,0,0,1, then `done`. `len`=1 → one bit (data MSB), then `done`.
- `load` held high continuously with alternating frames → exactly one `A`=0, `a_valid`=0 cycle between frames, and `done` on each gap cycle.
- `load` pulsed and `data` changed during SHIFT → the transmitted bits are unchanged and no extra frame is sent.
- With `PATTERN_TX_LOOP_EN`, `len`=5, `loop`=1 for 3 frames → 15 contiguous valid bits and a single `done` after the third frame.

Source files
------------

// File: rtl/fsm_pattern_pkg.sv
// Shared types and constants for the bit-serial pattern transmitter.
// Holds the FSM state encoding and the default frame width.
package fsm_pattern_pkg;

  localparam int PATTERN_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_bit_cnt.sv
// Loadable down-counter that tracks how many frame bits remain to be sent.
// Load has priority over decrement; the count saturates at zero and never wraps.
module pattern_bit_cnt #(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic [LEN_W-1:0] value,
  output logic             last
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;

  // Next count: reload, step down, or hold (zero is sticky).
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign last  = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/fsm_pattern_tx.sv
// Bit-serial pattern transmitter: latches a parallel word on a ready/load
// handshake and shifts it out MSB-first on A, one bit per clock.
// Optional build macro PATTERN_TX_LOOP_EN adds a 'loop' input that replays the
// latched frame back-to-back with no gap until loop is dropped.
module fsm_pattern_tx
  import fsm_pattern_pkg::*;
#(
  parameter int WIDTH = PATTERN_WIDTH,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
`ifdef PATTERN_TX_LOOP_EN
  input  logic             loop,
`endif
  output logic             ready,
  output logic             A,
  output logic             a_valid,
  output logic             done
);

  // Zero and oversize lengths both mean a full-width frame.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
    if ((l == '0) || (l > LEN_W'(WIDTH))) begin
      return LEN_W'(WIDTH);
    end
    return l;
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   sreg_q;
  logic [WIDTH-1:0]   sreg_d;

  logic               cnt_load;
  logic               cnt_dec;
  logic [LEN_W-1:0]   cnt_load_val;
  logic [LEN_W-1:0]   cnt_value;
  logic               cnt_last;
  logic               last_bit;

`ifdef PATTERN_TX_LOOP_EN
  // Copy of the accepted frame so a looping frame can be replayed.
  logic [WIDTH-1:0]   frame_q;
  logic [WIDTH-1:0]   frame_d;
  logic [LEN_W-1:0]   flen_q;
  logic [LEN_W-1:0]   flen_d;
`endif

  pattern_bit_cnt #(
    .LEN_W (LEN_W)
  ) u_bit_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .last     (cnt_last)
  );

  // An empty counter in SHIFT cannot occur normally; treat it as the last bit
  // so the FSM can never get stuck shifting.
  assign last_bit = cnt_last || (cnt_value == '0);

  // Next-state, shift-register and counter control.
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = eff_len(len);
`ifdef PATTERN_TX_LOOP_EN
    frame_d      = frame_q;
    flen_d       = flen_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (load) begin
          sreg_d   = data;
          cnt_load = 1'b1;
          state_d  = SHIFT;
`ifdef PATTERN_TX_LOOP_EN
          frame_d  = data;
          flen_d   = eff_len(len);
`endif
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        sreg_d  = {sreg_q[WIDTH-2:0], 1'b0};
        cnt_dec = 1'b1;
        if (last_bit) begin
`ifdef PATTERN_TX_LOOP_EN
          if (loop) begin
            sreg_d       = frame_q;
            cnt_load     = 1'b1;
            cnt_load_val = flen_q;
            cnt_dec      = 1'b0;
          end else begin
            state_d      = DONE;
          end
`else
          state_d = DONE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and shift register; reset discards any partial frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

`ifdef PATTERN_TX_LOOP_EN
  // Replay copy of the most recently accepted frame and its length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q <= '0;
      flen_q  <= '0;
    end else begin
      frame_q <= frame_d;
      flen_q  <= flen_d;
    end
  end
`endif

  // Moore outputs decoded from state (and the registered MSB) only.
  assign ready   = (state_q != SHIFT);
  assign a_valid = (state_q == SHIFT);
  assign A       = (state_q == SHIFT) && sreg_q[WIDTH-1];
  assign done    = (state_q == DONE);

endmodule
